// File: rtl/rr_grant_encoder_if.sv
// rr_grant_encoder_if
//   Bundles the request/grant signals between a set of requesters and the
//   round-robin grant encoder.
//   Signals:
//     req           requester -> arbiter  one request line per requester
//     grant_release requester -> arbiter  current grant owner is done (pulse or level)
//     grant_idx     arbiter -> requester  binary index of the granted requester (decoder input)
//     grant_valid   arbiter -> requester  grant_idx is valid and selected
//     timeout       arbiter -> requester  one-cycle pulse on a forced revoke
//   Modports:
//     master  requester side (drives req/grant_release)
//     slave   arbiter side (drives grant_idx/grant_valid/timeout)
interface rr_grant_encoder_if #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
);
  logic [N_REQ-1:0] req;
  logic             grant_release;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req,
    output grant_release,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  grant_release,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder
//   8-requester round-robin arbiter that registers a binary grant index for
//   the downstream 3-to-8 select decoder. A grant is held until its owner
//   releases it (or drops its request); every grant is followed by a GAP
//   cycle and an IDLE arbitration cycle, so two selects never overlap.
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  asynchronous active-high reset
//     bus   rr_grant_encoder_if.slave
//             req[7:0] in, grant_release in,
//             grant_idx[2:0] out, grant_valid out, timeout out
//   Configuration:
//     RR_GRANT_TIMEOUT_EN  when defined, a grant is forcibly revoked after
//                          MAX_HOLD cycles and timeout pulses for one cycle.
//                          When undefined, no hold counter is built and
//                          timeout is tied low.
module rr_grant_encoder #(
  parameter int N_REQ    = 8,
  parameter int IDX_W    = 3
`ifdef RR_GRANT_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  rr_grant_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] winner_s;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;
  logic             owner_done_s;

`ifdef RR_GRANT_TIMEOUT_EN
  // Last count value at which the grant is still allowed to stand.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Round-robin search: first set request starting at ptr, wrapping mod 8.
  always_comb begin
    winner_s = ptr_q;
    cand_s   = ptr_q;
    found_s  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = ptr_q + IDX_W'(i);
      if (!found_s && bus.req[cand_s]) begin
        winner_s = cand_s;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // A dropped request from the owner ends the grant just like a release.
  always_comb begin
    owner_done_s = bus.grant_release || !bus.req[grant_idx_q];
  end

  // Next-state and registered-output logic for the IDLE/GRANT/GAP FSM.
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
`ifdef RR_GRANT_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_idx_d   = winner_s;
          grant_valid_d = 1'b1;
          state_d       = ST_GRANT;
`ifdef RR_GRANT_TIMEOUT_EN
          hold_cnt_d    = 8'd0;
`endif
        end else begin
          grant_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        // Release takes priority over the timeout, so a release arriving in
        // the last allowed cycle never produces a timeout pulse.
        if (owner_done_s) begin
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + IDX_W'(1);
          state_d       = ST_GAP;
        end
`ifdef RR_GRANT_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LAST) begin
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + IDX_W'(1);
          state_d       = ST_GAP;
          timeout_d     = 1'b1;
        end
`endif
        else begin
          grant_valid_d = 1'b1;
`ifdef RR_GRANT_TIMEOUT_EN
          hold_cnt_d    = hold_cnt_q + 8'd1;
`endif
        end
      end
      ST_GAP: begin
        // Mandatory dead cycle; arbitration only resumes from IDLE.
        grant_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
      default: begin
        grant_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_cnt_q    <= 8'd0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
`ifdef RR_GRANT_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule
